mixcolumns_serial: RTL and testbench

- Byte-serial AES MixColumns stage; sits directly downstream of the byte-serial ShiftRows stage.
- Consumes its `outbyte`/`ready` stream one byte per clock and buffers each 4-byte column.
- Emits the GF(2^8)-mixed column as a 4-byte burst, while collecting the next column in parallel.
- A per-column bypass passes bytes through unmixed for the final AES round.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/mixcol_row.sv | 34 +++
 rtl/mixcolumns_serial.sv | 121 ++++++++++++
 tb/tb_mixcolumns_serial.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// GF(2^8) helpers and output-FSM encoding shared by the byte-serial MixColumns stage.
// Inverse multipliers are only used when MIXCOL_INV_EN is defined.
package aes_pkg;

   localparam logic [7:0] AES_REDUCE = 8'h1B;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OUT0 = 3'd1,
      ST_OUT1 = 3'd2,
      ST_OUT2 = 3'd3,
      ST_OUT3 = 3'd4
   } out_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_REDUCE : 8'h00);
   endfunction

   function automatic logic [7:0] gmul02(input logic [7:0] a);
      return xtime(a);
   endfunction

   function automatic logic [7:0] gmul03(input logic [7:0] a);
      return xtime(a) ^ a;
   endfunction

   // Inverse coefficients built from x, x^2, x^3 terms.
   function automatic logic [7:0] gmul09(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

endpackage

// File: rtl/mixcol_row.sv
// Combinational single-row MixColumns: rotates the column so the selected row leads, then mixes.
// The inverse port and multipliers exist only with MIXCOL_INV_EN.
module mixcol_row
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic [1:0]  row,
`ifdef MIXCOL_INV_EN
   input  logic        inverse,
`endif
   output logic [7:0]  mixed
);

   logic [7:0] rot [4];
   logic [7:0] fwd;

   // rot[k] = a_(row+k mod 4); row 0 sits in the low byte of col
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] sel;
      assign sel     = row + 2'(gi);
      assign rot[gi] = col[{sel, 3'b000} +: 8];
   end

   assign fwd = gmul02(rot[0]) ^ gmul03(rot[1]) ^ rot[2] ^ rot[3];

`ifdef MIXCOL_INV_EN
   assign mixed = inverse ? (gmul0e(rot[0]) ^ gmul0b(rot[1]) ^ gmul0d(rot[2]) ^ gmul09(rot[3]))
                          : fwd;
`else
   assign mixed = fwd;
`endif

endmodule

// File: rtl/mixcolumns_serial.sv
// Byte-serial AES MixColumns: collects 4-byte columns and drains each mixed column as a 4-byte burst.
// Define MIXCOL_INV_EN to add the inverse port and InvMixColumns.
module mixcolumns_serial
   import aes_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] inbyte,
   input  logic       in_valid,
   input  logic       last_round,
`ifdef MIXCOL_INV_EN
   input  logic       inverse,
`endif
   output logic [7:0] outbyte,
   output logic       ready
);

   logic [1:0]  cidx_reg;
   logic [23:0] col_buf_reg;
   logic [31:0] hold_reg;
   logic        hold_byp_reg;
   out_state_t  state_reg, state_next;
   logic [7:0]  outbyte_reg;
   logic        ready_reg;

   logic        col_complete;
   logic [31:0] new_col;
   logic [31:0] mix_src;
   logic        mix_byp;
   logic [1:0]  mix_row;
   logic [7:0]  row_mixed;
   logic [7:0]  row_val;

   assign col_complete = in_valid && (cidx_reg == 2'd3);
   assign new_col      = {inbyte, col_buf_reg};

   // The first row of a new column is registered on the completing edge, so the mixer
   // looks at the incoming column then, and at the hold register for the remaining rows.
   assign mix_src = col_complete ? new_col : hold_reg;
   assign mix_byp = col_complete ? last_round : hold_byp_reg;

`ifdef MIXCOL_INV_EN
   logic hold_inv_reg;
   logic mix_inv;
   assign mix_inv = col_complete ? inverse : hold_inv_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         hold_inv_reg <= 1'b0;
      else if (col_complete)
         hold_inv_reg <= inverse;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cidx_reg     <= 2'd0;
         col_buf_reg  <= '0;
         hold_reg     <= '0;
         hold_byp_reg <= 1'b0;
      end else if (in_valid) begin
         cidx_reg <= cidx_reg + 2'd1;
         case (cidx_reg)
            2'd0:    col_buf_reg[7:0]   <= inbyte;
            2'd1:    col_buf_reg[15:8]  <= inbyte;
            2'd2:    col_buf_reg[23:16] <= inbyte;
            default: begin
               hold_reg     <= new_col;
               hold_byp_reg <= last_round;
            end
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      mix_row    = 2'd0;
      case (state_reg)
         ST_IDLE: if (col_complete) state_next = ST_OUT0;
         ST_OUT0: state_next = ST_OUT1;
         ST_OUT1: state_next = ST_OUT2;
         ST_OUT2: state_next = ST_OUT3;
         ST_OUT3: state_next = col_complete ? ST_OUT0 : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      case (state_next)
         ST_OUT1: mix_row = 2'd1;
         ST_OUT2: mix_row = 2'd2;
         ST_OUT3: mix_row = 2'd3;
         default: mix_row = 2'd0;
      endcase
   end

   mixcol_row u_mixcol_row (
      .col     (mix_src),
`ifdef MIXCOL_INV_EN
      .inverse (mix_inv),
`endif
      .row     (mix_row),
      .mixed   (row_mixed)
   );

   assign row_val = mix_byp ? mix_src[{mix_row, 3'b000} +: 8] : row_mixed;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         outbyte_reg <= 8'h00;
         ready_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next != ST_IDLE);
         if (state_next != ST_IDLE)
            outbyte_reg <= row_val;
      end
   end

   assign outbyte = outbyte_reg;
   assign ready   = ready_reg;

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Directed bench for mixcolumns_serial with FIPS-197 MixColumns vectors; inverse case under MIXCOL_INV_EN.
module tb_mixcolumns_serial;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] inbyte;
   logic       in_valid;
   logic       last_round;
   logic       inverse;
   logic [7:0] outbyte;
   logic       ready;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   mixcolumns_serial dut (
      .clock      (clock),
      .reset      (reset),
      .inbyte     (inbyte),
      .in_valid   (in_valid),
      .last_round (last_round),
`ifdef MIXCOL_INV_EN
      .inverse    (inverse),
`endif
      .outbyte    (outbyte),
      .ready      (ready)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input, then check ready/outbyte just after the edge.
   task automatic step(input logic v, input logic [7:0] b, input logic lr,
                       input logic er, input logic [7:0] eo, input string tag);
      @(negedge clock);
      in_valid   = v;
      inbyte     = b;
      last_round = lr;
      @(posedge clock);
      #1;
      $display("%s: in_valid=%0b inbyte=%h -> ready=%0b outbyte=%h", tag, v, b, ready, outbyte);
      chk({tag, ".ready"}, {7'd0, ready}, {7'd0, er});
      chk({tag, ".outbyte"}, outbyte, eo);
   endtask

   initial begin
      reset = 1'b1; inbyte = 8'h00; in_valid = 1'b0; last_round = 1'b0; inverse = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset.ready", {7'd0, ready}, 8'h00);
      chk("reset.outbyte", outbyte, 8'h00);
      @(negedge clock);
      reset = 1'b0;

      // Continuous forward; last_round toggled on rows 0-2 must not matter
      step(1, 8'hdb, 1, 0, 8'h00, "fwd0");
      step(1, 8'h13, 1, 0, 8'h00, "fwd1");
      step(1, 8'h53, 1, 0, 8'h00, "fwd2");
      step(1, 8'h45, 0, 1, 8'h8e, "fwd3");
      step(0, 8'h00, 0, 1, 8'h4d, "fwd4");
      step(0, 8'h00, 0, 1, 8'ha1, "fwd5");
      step(0, 8'h00, 0, 1, 8'hbc, "fwd6");
      step(0, 8'h00, 0, 0, 8'hbc, "fwd7");

      // Back-to-back columns, no bubble
      step(1, 8'hd4, 0, 0, 8'hbc, "b2b0");
      step(1, 8'hbf, 0, 0, 8'hbc, "b2b1");
      step(1, 8'h5d, 0, 0, 8'hbc, "b2b2");
      step(1, 8'h30, 0, 1, 8'h04, "b2b3");
      step(1, 8'hf2, 0, 1, 8'h66, "b2b4");
      step(1, 8'h0a, 0, 1, 8'h81, "b2b5");
      step(1, 8'h22, 0, 1, 8'he5, "b2b6");
      step(1, 8'h5c, 0, 1, 8'h9f, "b2b7");
      step(0, 8'h00, 0, 1, 8'hdc, "b2b8");
      step(0, 8'h00, 0, 1, 8'h58, "b2b9");
      step(0, 8'h00, 0, 1, 8'h9d, "b2b10");
      step(0, 8'h00, 0, 0, 8'h9d, "b2b11");

      // Gapped input
      step(1, 8'hc6, 0, 0, 8'h9d, "gap0");
      step(1, 8'hc6, 0, 0, 8'h9d, "gap1");
      for (int i = 0; i < 5; i++) step(0, 8'h77, 0, 0, 8'h9d, "gap_idle");
      step(1, 8'hc6, 0, 0, 8'h9d, "gap2");
      step(1, 8'hc6, 0, 1, 8'hc6, "gap3");
      step(0, 8'h00, 0, 1, 8'hc6, "gap4");
      step(0, 8'h00, 0, 1, 8'hc6, "gap5");
      step(0, 8'h00, 0, 1, 8'hc6, "gap6");
      step(0, 8'h00, 0, 0, 8'hc6, "gap7");

      // Bypass on the last round
      step(1, 8'hdb, 0, 0, 8'hc6, "byp0");
      step(1, 8'h13, 0, 0, 8'hc6, "byp1");
      step(1, 8'h53, 0, 0, 8'hc6, "byp2");
      step(1, 8'h45, 1, 1, 8'hdb, "byp3");
      step(0, 8'h00, 0, 1, 8'h13, "byp4");
      step(0, 8'h00, 0, 1, 8'h53, "byp5");
      step(0, 8'h00, 0, 1, 8'h45, "byp6");
      step(0, 8'h00, 0, 0, 8'h45, "byp7");

      // Reset during OUT1 while a partial column is also being collected
      step(1, 8'hdb, 0, 0, 8'h45, "rst0");
      step(1, 8'h13, 0, 0, 8'h45, "rst1");
      step(1, 8'h53, 0, 0, 8'h45, "rst2");
      step(1, 8'h45, 0, 1, 8'h8e, "rst3");
      step(1, 8'h55, 0, 1, 8'h4d, "rst4");
      @(negedge clock);
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      $display("rst_async: ready=%0b outbyte=%h", ready, outbyte);
      chk("rst_async.ready", {7'd0, ready}, 8'h00);
      chk("rst_async.outbyte", outbyte, 8'h00);
      @(negedge clock);
      reset = 1'b0;
      step(1, 8'h01, 0, 0, 8'h00, "post0");
      step(1, 8'h01, 0, 0, 8'h00, "post1");
      step(1, 8'h01, 0, 0, 8'h00, "post2");
      step(1, 8'h01, 0, 1, 8'h01, "post3");
      step(0, 8'h00, 0, 1, 8'h01, "post4");
      step(0, 8'h00, 0, 1, 8'h01, "post5");
      step(0, 8'h00, 0, 1, 8'h01, "post6");
      step(0, 8'h00, 0, 0, 8'h01, "post7");

`ifdef MIXCOL_INV_EN
      inverse = 1'b1;
      step(1, 8'h8e, 0, 0, 8'h01, "inv0");
      step(1, 8'h4d, 0, 0, 8'h01, "inv1");
      step(1, 8'ha1, 0, 0, 8'h01, "inv2");
      step(1, 8'hbc, 0, 1, 8'hdb, "inv3");
      inverse = 1'b0;
      step(0, 8'h00, 0, 1, 8'h13, "inv4");
      step(0, 8'h00, 0, 1, 8'h53, "inv5");
      step(0, 8'h00, 0, 1, 8'h45, "inv6");
      step(0, 8'h00, 0, 0, 8'h45, "inv7");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
